// File: rtl/cdb_arbiter.sv
// cdb_arbiter: selects one finished functional-unit result per cycle and drives
// the registered Common Data Bus broadcast.
// Build option: define CDB_ROUND_ROBIN_EN for rotating priority. Without it the
// lowest requesting index always wins and no priority pointer is kept.
module cdb_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned TAG_W   = 7,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      cdb_valid,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic [DATA_W-1:0]         cdb_data,
   output logic [SRC_W-1:0]          cdb_src
);

   localparam int unsigned LAST_IDX = NUM_REQ - 1;

   logic [SRC_W-1:0]  ptr;
   logic              grant_any;
   logic [SRC_W-1:0]  grant_idx;
   logic [TAG_W-1:0]  win_tag;
   logic [DATA_W-1:0] win_data;

   // Winner search: first requester scanning from ptr upward, wrapping past the top
   always_comb begin
      int unsigned      ofs;
      logic [SRC_W-1:0] cand;
      grant_any = 1'b0;
      grant_idx = '0;
      ofs       = 0;
      cand      = '0;
      if (!reset && !flush) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            ofs = 32'(ptr) + k;
            if (ofs >= NUM_REQ) begin
               ofs = ofs - NUM_REQ;
            end
            cand = SRC_W'(ofs);
            if (!grant_any && req_valid[cand]) begin
               grant_any = 1'b1;
               grant_idx = cand;
            end
         end
      end
   end

   // One-hot grant and winner payload mux, decoded from the winning index
   always_comb begin
      req_ready = '0;
      win_tag   = '0;
      win_data  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_any && (grant_idx == SRC_W'(i))) begin
            req_ready[i] = 1'b1;
            win_tag      = req_tag[i*TAG_W +: TAG_W];
            win_data     = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef CDB_ROUND_ROBIN_EN
   // Priority pointer: moves to the unit just after the one that transferred
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr <= '0;
      end else if (grant_any) begin
         ptr <= (grant_idx == SRC_W'(LAST_IDX)) ? '0 : grant_idx + SRC_W'(1);
      end
   end
`else
   // Fixed priority: scan always starts at unit 0
   assign ptr = '0;
`endif

   // Broadcast register: load the winner, otherwise drop valid and hold payload
   always_ff @(posedge clock) begin
      if (reset) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_data  <= '0;
         cdb_src   <= '0;
      end else begin
         cdb_valid <= grant_any;
         if (grant_any) begin
            cdb_tag  <= win_tag;
            cdb_data <= win_data;
            cdb_src  <= grant_idx;
         end
      end
   end

endmodule
